// File: rtl/wb_pipe_ram_slave_pkg.sv
// Shared definitions for the pipelined Wishbone RAM slave.
//   state_t   : service FSM encoding (IDLE / WAIT / ACCESS)
//   DATA_W    : bus data width
//   SEL_W     : byte-lane select width
//   WCNT_W    : wait-state counter width (WAIT_CYCLES up to 15)
//   entry_w() : width of one request-queue entry for a given word-address width.
//               Entry packing is {range_err, we, sel[3:0], data[31:0], word_idx}.
package wb_pipe_ram_slave_pkg;

  localparam int DATA_W = 32;
  localparam int SEL_W  = 4;
  localparam int WCNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ACCESS = 2'd2
  } state_t;

  function automatic int entry_w(input int adr_bits);
    return adr_bits + DATA_W + SEL_W + 2;
  endfunction

endpackage

// File: rtl/wb_pipe_ram_slave_req_fifo.sv
// wbs_req_fifo: two-entry synchronous request FIFO for the Wishbone RAM slave.
// Ports:
//   clk, rstn      : clock, asynchronous active-low clear of pointers/count
//   push, pop      : enqueue din / dequeue head (caller never overflows/underflows)
//   flush          : discard all entries (wins over push/pop)
//   din, dout      : entry in, current head entry out
//   count          : number of valid entries (0..2)
module wbs_req_fifo
  import wb_pipe_ram_slave_pkg::*;
#(
  parameter int ENTRY_W = entry_w(11)
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               push,
  input  logic               pop,
  input  logic               flush,
  input  logic [ENTRY_W-1:0] din,
  output logic [ENTRY_W-1:0] dout,
  output logic [1:0]         count
);

  logic [ENTRY_W-1:0] slot [2];
  logic               wr_ptr;
  logic               rd_ptr;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Payload storage carries no reset; validity is tracked by count alone.
  always_ff @(posedge clk) begin
    if (push && !flush) slot[wr_ptr] <= din;
  end

  assign dout = slot[rd_ptr];

endmodule

// File: rtl/wb_pipe_ram_slave.sv
// wb_pipe_ram_slave: pipelined Wishbone B4 slave backed by a byte-writable RAM.
// Requests are queued in a two-entry FIFO and serviced strictly in order with
// WAIT_CYCLES extra latency (0..15); latency from accept edge to ack sample is
// 2 + WAIT_CYCLES.
// Optional feature macro: WB_SLAVE_ERR_EN adds the wb_err port and flags
// requests whose address lies above the RAM (no write, wb_err instead of wb_ack).
// Ports:
//   clk, rstn            : clock, asynchronous active-low reset
//   wb_adr, wb_in        : byte address, write data
//   wb_sel, wb_we        : byte lanes, write enable
//   wb_cyc, wb_stb       : bus cycle, request strobe (cyc low aborts queued work)
//   wb_out, wb_ack       : read data / one-cycle response
//   wb_stall             : queue full, request not accepted
//   wb_err               : range-error response (WB_SLAVE_ERR_EN only)
module wb_pipe_ram_slave
  import wb_pipe_ram_slave_pkg::*;
#(
  parameter int ADR_BITS    = 11,
  parameter int WAIT_CYCLES = 0
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [31:0]       wb_adr,
  input  logic [DATA_W-1:0] wb_in,
  output logic [DATA_W-1:0] wb_out,
  input  logic [SEL_W-1:0]  wb_sel,
  input  logic              wb_cyc,
  input  logic              wb_stb,
  input  logic              wb_we,
  output logic              wb_ack,
  output logic              wb_stall
`ifdef WB_SLAVE_ERR_EN
  ,
  output logic              wb_err
`endif
);

  localparam int ENTRY_W = entry_w(ADR_BITS);

  logic [ENTRY_W-1:0]  push_entry;
  logic [ENTRY_W-1:0]  head_entry;
  logic [1:0]          count;
  logic                accept;
  logic                do_access;
  logic                ram_we;
  logic                range_err;
  logic                unused_adr;
  logic [ADR_BITS-1:0] head_idx;
  logic [DATA_W-1:0]   head_data;
  logic [SEL_W-1:0]    head_sel;
  logic                head_we;
  logic                head_err;
  state_t              state;
  logic [WCNT_W-1:0]   wcnt;
  logic [DATA_W-1:0]   ram [2**ADR_BITS];

`ifdef WB_SLAVE_ERR_EN
  assign range_err  = (wb_adr[31:ADR_BITS+2] != '0);
  assign unused_adr = ^wb_adr[1:0];
`else
  // Upper address bits are ignored, so the RAM aliases across the 32-bit space.
  assign range_err  = 1'b0;
  assign unused_adr = ^{wb_adr[31:ADR_BITS+2], wb_adr[1:0]};
`endif

  // Stall looks only at the registered count; a pop on the same edge does not
  // open a slot early.
  assign wb_stall   = (count == 2'd2);
  assign accept     = wb_cyc & wb_stb & ~wb_stall;
  assign push_entry = {range_err, wb_we, wb_sel, wb_in, wb_adr[ADR_BITS+1:2]};
  assign {head_err, head_we, head_sel, head_data, head_idx} = head_entry;

  wbs_req_fifo #(
    .ENTRY_W (ENTRY_W)
  ) u_req_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (accept),
    .pop   (do_access),
    .flush (~wb_cyc),
    .din   (push_entry),
    .dout  (head_entry),
    .count (count)
  );

  // The RAM operation happens on the edge that enters ACCESS; the ACCESS state
  // itself is the cycle during which the response is on the bus.
  always_comb begin
    do_access = 1'b0;
    case (state)
      ST_IDLE:   do_access = (count != 2'd0) && (WAIT_CYCLES == 0);
      ST_WAIT:   do_access = (wcnt == '0);
      ST_ACCESS: do_access = (count != 2'd0) && (WAIT_CYCLES == 0);
      default:   do_access = 1'b0;
    endcase
  end

  // A write reaching its access edge commits even if the master aborts then.
  assign ram_we = do_access & head_we & ~head_err;

  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int b = 0; b < SEL_W; b++) begin
        if (head_sel[b]) ram[head_idx][8*b +: 8] <= head_data[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state  <= ST_IDLE;
      wcnt   <= '0;
      wb_ack <= 1'b0;
      wb_out <= '0;
`ifdef WB_SLAVE_ERR_EN
      wb_err <= 1'b0;
`endif
    end else begin
      wb_ack <= 1'b0;
      wb_out <= '0;
`ifdef WB_SLAVE_ERR_EN
      wb_err <= 1'b0;
`endif
      if (!wb_cyc) begin
        state <= ST_IDLE;
        wcnt  <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (count != 2'd0) begin
              if (WAIT_CYCLES > 0) begin
                state <= ST_WAIT;
                wcnt  <= WCNT_W'(WAIT_CYCLES - 1);
              end else begin
                state <= ST_ACCESS;
              end
            end
          end
          ST_WAIT: begin
            if (wcnt == '0) state <= ST_ACCESS;
            else            wcnt  <= wcnt - 1'b1;
          end
          ST_ACCESS: begin
            if (count != 2'd0) begin
              if (WAIT_CYCLES > 0) begin
                state <= ST_WAIT;
                wcnt  <= WCNT_W'(WAIT_CYCLES - 1);
              end else begin
                state <= ST_ACCESS;
              end
            end else begin
              state <= ST_IDLE;
            end
          end
          default: state <= ST_IDLE;
        endcase

        if (do_access) begin
          wb_ack <= ~head_err;
          wb_out <= (head_we || head_err) ? '0 : ram[head_idx];
`ifdef WB_SLAVE_ERR_EN
          wb_err <= head_err;
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_wb_pipe_ram_slave.sv
// Self-checking bench for wb_pipe_ram_slave. Two instances: WAIT_CYCLES=0 and
// WAIT_CYCLES=3; one is exercised at a time while the other sees wb_cyc low.
// The reference model predicts each request's access edge from the rule
// X_i = max(accept_edge_i, X_{i-1}) + 1 + WAIT, keeps the RAM as byte-tracked
// associative arrays and the outstanding requests in a queue.
// Macro WB_SLAVE_ERR_EN (if defined) also enables range-error checking.
module tb_wb_pipe_ram_slave;

  localparam int AB = 11;

  typedef struct {
    int          idx;
    logic [31:0] data;
    logic [3:0]  sel;
    bit          we;
    bit          rerr;
    longint      x;
  } req_t;

  logic        clk = 1'b0;
  logic        rstn;
  logic [31:0] adr [2];
  logic [31:0] din [2];
  logic [31:0] dout [2];
  logic [3:0]  sel [2];
  logic        cyc [2];
  logic        stb [2];
  logic        we [2];
  logic        ack [2];
  logic        stall [2];
`ifdef WB_SLAVE_ERR_EN
  logic        err [2];
`endif

  int          n_checks = 0;
  int          n_errors = 0;
  int          cur = 0;
  int          n_ack = 0;
  logic [31:0] last_out = '0;
  logic        last_stall = 1'b0;
  longint      e = 0;
  longint      lastx = 0;
  req_t        q[$];
  logic [31:0] mdl_mem [int];
  logic [3:0]  mdl_vld [int];

  always #5 clk = ~clk;

  wb_pipe_ram_slave #(.ADR_BITS(AB), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .rstn(rstn), .wb_adr(adr[0]), .wb_in(din[0]), .wb_out(dout[0]),
    .wb_sel(sel[0]), .wb_cyc(cyc[0]), .wb_stb(stb[0]), .wb_we(we[0]),
    .wb_ack(ack[0]), .wb_stall(stall[0])
`ifdef WB_SLAVE_ERR_EN
    , .wb_err(err[0])
`endif
  );

  wb_pipe_ram_slave #(.ADR_BITS(AB), .WAIT_CYCLES(3)) u_dut1 (
    .clk(clk), .rstn(rstn), .wb_adr(adr[1]), .wb_in(din[1]), .wb_out(dout[1]),
    .wb_sel(sel[1]), .wb_cyc(cyc[1]), .wb_stb(stb[1]), .wb_we(we[1]),
    .wb_ack(ack[1]), .wb_stall(stall[1])
`ifdef WB_SLAVE_ERR_EN
    , .wb_err(err[1])
`endif
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s dut=%0d t=%0t got=%h want=%h", tag, cur, $time, act, exp);
    end
  endtask

  // One bus cycle: drive inputs (called just after a falling edge), check stall,
  // advance the model across the rising edge, check the response.
  task automatic tick(input bit c, input bit s, input bit w, input logic [31:0] a,
                      input logic [31:0] d, input logic [3:0] sl, output bit acc);
    req_t        h;
    req_t        n;
    int          wt;
    int          key;
    bit          eack;
    bit          eerr;
    logic [31:0] eout;
    logic [31:0] emask;
    logic [31:0] tmp;
    logic [3:0]  vld;
    wt = (cur == 1) ? 3 : 0;
    cyc[cur] = c; stb[cur] = s; we[cur] = w; adr[cur] = a; din[cur] = d; sel[cur] = sl;
    #1;
    last_stall = stall[cur];
    check("stall", 32'(stall[cur]), 32'(q.size() == 2));
    acc = c && s && (q.size() != 2);
    @(posedge clk);
    e++;
    eack = 1'b0; eerr = 1'b0; eout = '0; emask = 32'hFFFF_FFFF;
    if (q.size() != 0 && q[0].x == e) begin
      h   = q.pop_front();
      key = cur * 4096 + h.idx;
      if (!h.rerr) begin
        tmp = mdl_mem.exists(key) ? mdl_mem[key] : 32'h0;
        vld = mdl_vld.exists(key) ? mdl_vld[key] : 4'h0;
        if (h.we) begin
          for (int b = 0; b < 4; b++) begin
            if (h.sel[b]) begin
              tmp[8*b +: 8] = h.data[8*b +: 8];
              vld[b] = 1'b1;
            end
          end
          mdl_mem[key] = tmp;
          mdl_vld[key] = vld;
        end else begin
          eout = tmp;
          for (int b = 0; b < 4; b++) emask[8*b +: 8] = vld[b] ? 8'hFF : 8'h00;
        end
      end
      if (c) begin
        eack = !h.rerr;
        eerr = h.rerr;
      end
    end
    if (!c) begin
      q.delete();
      lastx = e;
    end else if (acc) begin
      n.idx  = int'(a[AB+1:2]);
      n.data = d;
      n.sel  = sl;
      n.we   = w;
`ifdef WB_SLAVE_ERR_EN
      n.rerr = (a[31:AB+2] != '0);
`else
      n.rerr = 1'b0;
`endif
      n.x    = ((e > lastx) ? e : lastx) + 1 + wt;
      lastx  = n.x;
      q.push_back(n);
    end
    @(negedge clk);
    check("ack", 32'(ack[cur]), 32'(eack));
`ifdef WB_SLAVE_ERR_EN
    check("err", 32'(err[cur]), 32'(eerr));
`endif
    if (eack) check("rdata", dout[cur] & emask, eout & emask);
    if (ack[cur]) begin
      n_ack++;
      last_out = dout[cur];
    end
  endtask

  task automatic idle(input int cycles);
    bit acc;
    for (int i = 0; i < cycles; i++) tick(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, acc);
  endtask

  // Keep strobing the same request until it is accepted (bounded).
  task automatic send(input bit w, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] sl);
    bit acc;
    int tries;
    tries = 0;
    acc   = 1'b0;
    while (!acc && tries < 20) begin
      tick(1'b1, 1'b1, w, a, d, sl, acc);
      tries++;
    end
    if (!acc) check("accept_timeout", 32'(acc), 32'd1);
  endtask

  task automatic mid_reset();
    #2 rstn = 1'b0;
    #1;
    check("rst_ack", 32'(ack[cur]), 32'd0);
    check("rst_stall", 32'(stall[cur]), 32'd0);
    check("rst_out", dout[cur], 32'd0);
    q.delete();
    lastx = e;
    cyc[cur] = 1'b0; stb[cur] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic random_run(input int cycles);
    bit          acc;
    bit          c;
    bit          s;
    bit          w;
    logic [31:0] a;
    logic [18:0] hi;
    for (int i = 0; i < cycles; i++) begin
      c  = ($urandom_range(0, 24) != 0);
      s  = ($urandom_range(0, 9) < 7);
      w  = 1'($urandom_range(0, 1));
      hi = ($urandom_range(0, 3) == 0) ? 19'($urandom) : 19'd0;
      a  = {hi, 7'd0, 4'($urandom_range(0, 15)), 2'b00};
      tick(c, s, w, a, $urandom, 4'($urandom), acc);
    end
  endtask

  initial begin
    bit acc;
    logic st3;
    rstn = 1'b0;
    for (int k = 0; k < 2; k++) begin
      adr[k] = '0; din[k] = '0; sel[k] = '0; cyc[k] = 1'b0; stb[k] = 1'b0; we[k] = 1'b0;
    end
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      cur = k;
      check("reset_ack", 32'(ack[k]), 32'd0);
      check("reset_stall", 32'(stall[k]), 32'd0);
      check("reset_out", dout[k], 32'd0);
    end
    @(negedge clk);
    rstn = 1'b1;

    // ---- WAIT_CYCLES = 0 ----
    cur = 0;
    tick(1, 1, 1, 32'h10, 32'hDEAD_BEEF, 4'hF, acc);
    tick(1, 1, 1, 32'h10, 32'h0000_00AA, 4'h1, acc);
    tick(1, 1, 0, 32'h10, 32'h0, 4'hF, acc);
    idle(3);
    check("lane_rd", last_out, 32'hDEAD_BEAA);

    for (int i = 0; i < 8; i++) tick(1, 1, 1, 32'(i * 4), $urandom, 4'hF, acc);
    idle(1);
    n_ack = 0;
    for (int i = 0; i < 8; i++) tick(1, 1, 0, 32'(i * 4), 32'h0, 4'hF, acc);
    idle(3);
    check("stream_acks", 32'(n_ack), 32'd8);

`ifdef WB_SLAVE_ERR_EN
    tick(1, 1, 1, 32'h0, 32'h1234_5678, 4'hF, acc);
    tick(1, 1, 1, 32'h0400_0000, 32'hFFFF_FFFF, 4'hF, acc);
    tick(1, 1, 0, 32'h0, 32'h0, 4'hF, acc);
    idle(3);
    check("range_word0", last_out, 32'h1234_5678);
`endif

    random_run(300);
    idle(4);
    cyc[0] = 1'b0; stb[0] = 1'b0;

    // ---- WAIT_CYCLES = 3 ----
    cur = 1;
    idle(10);
    n_ack = 0;
    st3 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      send(1'b1, 32'(i * 4), 32'hA5A5_0000 | 32'(i), 4'hF);
      if (i == 1) begin
        // first strobe of the third request: both slots are occupied
        tick(1, 1, 1, 32'h8, 32'hA5A5_0002, 4'hF, acc);
        st3 = last_stall;
        if (acc) i++;
      end
    end
    idle(20);
    check("ws_stall3", 32'(st3), 32'd1);
    check("ws_acks", 32'(n_ack), 32'd4);

    // abort with two requests queued, then a normal read
    idle(5);
    send(1'b1, 32'h14, 32'h1111_1111, 4'hF);
    send(1'b1, 32'h14, 32'h2222_2222, 4'hF);
    tick(0, 0, 0, 32'h0, 32'h0, 4'h0, acc);
    n_ack = 0;
    tick(1, 1, 0, 32'h4, 32'h0, 4'hF, acc);
    idle(8);
    check("abort_acks", 32'(n_ack), 32'd1);
    check("abort_rd", last_out, 32'hA5A5_0001);

    random_run(300);
    idle(12);

    // reset with requests outstanding: nothing comes back afterwards
    send(1'b0, 32'h0, 32'h0, 4'hF);
    send(1'b0, 32'h4, 32'h0, 4'hF);
    mid_reset();
    n_ack = 0;
    idle(10);
    check("rst_burst_acks", 32'(n_ack), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
